// File: rtl/uart_word_sender.sv
// uart_word_sender: reads a run of W_D-bit words from a synchronous single-port
// RAM and hands them to a UART transmitter one byte at a time, least-significant
// byte first, through the transmitter's one-cycle enable / ready handshake.
// Build option: define UART_WORD_SENDER_CHECKSUM_EN to append one mod-256
// checksum byte (sum of all transmitted data bytes) after the last data byte.
module uart_word_sender #(
    parameter int W_D = 32,
    parameter int W_A = 3
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           start,
    input  logic [W_A:0]   start_len,
    output logic           busy,
    output logic           done,
    output logic [W_A-1:0] mem_addr,
    output logic           mem_re,
    input  logic [W_D-1:0] mem_q,
    output logic [7:0]     send_data,
    output logic           send_enable,
    input  logic           send_ready
);

    localparam int NB   = W_D / 8;
    localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(NB - 1);

    // S_GUARD / S_CGUARD exist because the UART still reports ready in the
    // cycle right after it was strobed; S_DONE is the visible done cycle.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_READ   = 4'd1,
        S_LATCH  = 4'd2,
        S_SEND   = 4'd3,
        S_GUARD  = 4'd4,
        S_CKSUM  = 4'd5,
        S_CGUARD = 4'd6,
        S_DRAIN  = 4'd7,
        S_FIN    = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    state_t          state_r, state_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic [W_A-1:0]  mem_addr_r, mem_addr_s;
    logic            mem_re_r, mem_re_s;
    logic [7:0]      send_data_r, send_data_s;
    logic            send_enable_r, send_enable_s;
    logic [W_A:0]    len_r, len_s;
    logic [W_A:0]    word_cnt_r, word_cnt_s;
    logic [W_A:0]    word_next_s;
    logic [BI_W-1:0] byte_idx_r, byte_idx_s;
    logic [W_D-1:0]  shift_r, shift_s;

`ifdef UART_WORD_SENDER_CHECKSUM_EN
    logic [7:0]      cksum_r, cksum_s;

    // Running checksum: modulo-256 sum of bytes.
    function automatic logic [7:0] add_mod256(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction
`endif

    assign busy        = busy_r;
    assign done        = done_r;
    assign mem_addr    = mem_addr_r;
    assign mem_re      = mem_re_r;
    assign send_data   = send_data_r;
    assign send_enable = send_enable_r;

    // Next-state and next-output decode; strobes default low every cycle.
    always_comb begin
        state_s       = state_r;
        busy_s        = busy_r;
        done_s        = 1'b0;
        mem_addr_s    = mem_addr_r;
        mem_re_s      = 1'b0;
        send_data_s   = send_data_r;
        send_enable_s = 1'b0;
        len_s         = len_r;
        word_cnt_s    = word_cnt_r;
        byte_idx_s    = byte_idx_r;
        shift_s       = shift_r;
        word_next_s   = word_cnt_r + (W_A+1)'(1);
`ifdef UART_WORD_SENDER_CHECKSUM_EN
        cksum_s       = cksum_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    busy_s = 1'b1;
`ifdef UART_WORD_SENDER_CHECKSUM_EN
                    cksum_s = 8'h00;
`endif
                    if (start_len != '0) begin
                        len_s      = start_len;
                        word_cnt_s = '0;
                        mem_addr_s = '0;
                        mem_re_s   = 1'b1;
                        state_s    = S_READ;
                    end else begin
`ifdef UART_WORD_SENDER_CHECKSUM_EN
                        state_s = S_CKSUM;
`else
                        state_s = S_FIN;
`endif
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_READ: begin
                // RAM captures mem_addr at the end of this cycle.
                state_s = S_LATCH;
            end
            S_LATCH: begin
                shift_s    = mem_q;
                byte_idx_s = '0;
                state_s    = S_SEND;
            end
            S_SEND: begin
                if (send_ready) begin
                    send_data_s   = shift_r[7:0];
                    send_enable_s = 1'b1;
                    shift_s       = shift_r >> 8;
`ifdef UART_WORD_SENDER_CHECKSUM_EN
                    cksum_s       = add_mod256(cksum_r, shift_r[7:0]);
`endif
                    state_s       = S_GUARD;
                end else begin
                    state_s = S_SEND;
                end
            end
            S_GUARD: begin
                if (byte_idx_r != LAST_BYTE) begin
                    byte_idx_s = byte_idx_r + BI_W'(1);
                    state_s    = S_SEND;
                end else if (word_next_s < len_r) begin
                    word_cnt_s = word_next_s;
                    mem_addr_s = mem_addr_r + W_A'(1);
                    mem_re_s   = 1'b1;
                    state_s    = S_READ;
                end else begin
                    word_cnt_s = word_next_s;
`ifdef UART_WORD_SENDER_CHECKSUM_EN
                    state_s    = S_CKSUM;
`else
                    state_s    = S_DRAIN;
`endif
                end
            end
`ifdef UART_WORD_SENDER_CHECKSUM_EN
            S_CKSUM: begin
                if (send_ready) begin
                    send_data_s   = cksum_r;
                    send_enable_s = 1'b1;
                    state_s       = S_CGUARD;
                end else begin
                    state_s = S_CKSUM;
                end
            end
            S_CGUARD: begin
                state_s = S_DRAIN;
            end
`endif
            S_DRAIN: begin
                // Ready returning means the last byte has left the UART.
                if (send_ready) begin
                    state_s = S_FIN;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_FIN: begin
                done_s  = 1'b1;
                state_s = S_DONE;
            end
            S_DONE: begin
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r       <= S_IDLE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            mem_addr_r    <= '0;
            mem_re_r      <= 1'b0;
            send_data_r   <= 8'h00;
            send_enable_r <= 1'b0;
            len_r         <= '0;
            word_cnt_r    <= '0;
            byte_idx_r    <= '0;
            shift_r       <= '0;
`ifdef UART_WORD_SENDER_CHECKSUM_EN
            cksum_r       <= 8'h00;
`endif
        end else begin
            state_r       <= state_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            mem_addr_r    <= mem_addr_s;
            mem_re_r      <= mem_re_s;
            send_data_r   <= send_data_s;
            send_enable_r <= send_enable_s;
            len_r         <= len_s;
            word_cnt_r    <= word_cnt_s;
            byte_idx_r    <= byte_idx_s;
            shift_r       <= shift_s;
`ifdef UART_WORD_SENDER_CHECKSUM_EN
            cksum_r       <= cksum_s;
`endif
        end
    end

endmodule

// File: tb/tb_uart_word_sender.sv
// Bench for uart_word_sender: RAM and UART models, a byte-list reference model,
// and one monitor that compares DUT activity to that model every cycle.
module tb_uart_word_sender;

    localparam int W_D   = 32;
    localparam int W_A   = 3;
    localparam int NB    = W_D / 8;
    localparam int DEPTH = 1 << W_A;

    logic           CLK;
    logic           RST_N;
    logic           start;
    logic [W_A:0]   start_len;
    logic           busy;
    logic           done;
    logic [W_A-1:0] mem_addr;
    logic           mem_re;
    logic [W_D-1:0] mem_q;
    logic [7:0]     send_data;
    logic           send_enable;
    logic           send_ready;

    logic [W_D-1:0] ram [DEPTH];
    logic [7:0]     exp_q [$];
    int             errors = 0;
    int             checks = 0;
    int             exp_len = 0;
    int             exp_addr = 0;
    bit             run_active = 1'b0;
    int             en_cnt = 0;
    int             done_cnt = 0;
    int             cyc = 0;
    int             last_en_cyc = -1;
    logic           prev_ready = 1'b0;
    bit             uart_up = 1'b0;
    bit             always_ready = 1'b0;
    int             hold_cycles = 20;
    int             hold_cnt = 0;
    int             lat;

    uart_word_sender #(.W_D(W_D), .W_A(W_A)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .start       (start),
        .start_len   (start_len),
        .busy        (busy),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_q       (mem_q),
        .send_data   (send_data),
        .send_enable (send_enable),
        .send_ready  (send_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: the byte stream a run of len words must produce.
    function automatic void build_exp(input int len);
        logic [W_D-1:0] w;
`ifdef UART_WORD_SENDER_CHECKSUM_EN
        logic [7:0] sum;
        sum = 8'h00;
`endif
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            w = ram[i];
            for (int k = 0; k < NB; k++) begin
                exp_q.push_back(w[8*k +: 8]);
`ifdef UART_WORD_SENDER_CHECKSUM_EN
                sum = sum + w[8*k +: 8];
`endif
            end
        end
`ifdef UART_WORD_SENDER_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
    endfunction

    // Synchronous RAM: data appears the cycle after mem_re is sampled.
    always @(posedge CLK) begin
        if (mem_re) mem_q <= ram[mem_addr];
    end

    // UART model: ready drops after a strobe and returns hold_cycles later.
    always @(posedge CLK) begin
        if (!uart_up) begin
            send_ready <= 1'b1;
            hold_cnt   <= 0;
        end else if (send_enable && !always_ready) begin
            send_ready <= 1'b0;
            hold_cnt   <= hold_cycles;
        end else if (hold_cnt > 0) begin
            hold_cnt <= hold_cnt - 1;
            if (hold_cnt == 1) send_ready <= 1'b1;
        end
    end

    // Monitor: every DUT strobe is checked against the model.
    always @(negedge CLK) begin
        cyc++;
        if (RST_N) begin
            if (send_enable) begin
                en_cnt++;
                chk("ready_before_enable", prev_ready, 1);
                if (last_en_cyc >= 0) chk("enable_gap_ge2", (cyc - last_en_cyc) >= 2, 1);
                last_en_cyc = cyc;
                chk("byte_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("send_data", send_data, exp_q.pop_front());
            end
            if (mem_re) begin
                chk("read_in_run", run_active && (exp_addr < exp_len), 1);
                chk("mem_addr", mem_addr, exp_addr);
                exp_addr++;
            end
            if (done) begin
                done_cnt++;
                chk("done_in_run", run_active, 1);
                chk("done_with_busy", busy, 1);
                chk("done_all_bytes", exp_q.size(), 0);
                chk("done_all_reads", exp_addr, exp_len);
            end
        end
        prev_ready = send_ready;
    end

    task automatic wait_done(input int d0, output int n);
        n = 1;
        while (done_cnt == d0 && n < 3000) begin
            @(posedge CLK); #2;
            n++;
        end
    endtask

    task automatic finish_run(input int d0);
        chk("done_pulses", done_cnt - d0, 1);
        chk("busy_after_done", busy, 0);
        chk("done_after_done", done, 0);
        chk("bytes_left", exp_q.size(), 0);
        chk("words_read", exp_addr, exp_len);
        run_active = 1'b0;
    endtask

    task automatic begin_run(input int len);
        build_exp(len);
        exp_len    = len;
        exp_addr   = 0;
        run_active = 1'b1;
        start      = 1'b1;
        start_len  = (W_A+1)'(len);
        @(posedge CLK); #2;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic do_run(input int len, output int n);
        int d0;
        d0 = done_cnt;
        begin_run(len);
        wait_done(d0, n);
        finish_run(d0);
    endtask

    task automatic wait_en(input int target);
        int n;
        n = 0;
        while (en_cnt < target && n < 3000) begin
            @(posedge CLK); #2;
            n++;
        end
        chk("wait_enable", en_cnt >= target, 1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int d0;
        RST_N     = 1'b0;
        start     = 1'b0;
        start_len = '0;
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        repeat (3) @(posedge CLK);
        #2;
        uart_up = 1'b1;
        chk("reset_outputs", {busy, done, mem_re, send_enable, mem_addr, send_data}, 0);
        RST_N = 1'b1;
        @(posedge CLK); #2;

        // Two known words, slow UART.
        ram[0] = 32'h44332211;
        ram[1] = 32'h88776655;
        build_exp(2);
        for (int k = 0; k < 8; k++) chk("model_pin_t1", exp_q[k], (k + 1) * 17);
        do_run(2, lat);

        // Empty run.
        do_run(0, lat);
`ifndef UART_WORD_SENDER_CHECKSUM_EN
        chk("len0_done_latency_le3", lat <= 3, 1);
`endif

        // Full-depth run, RAM[i] = i * 0x01010101.
        for (int i = 0; i < DEPTH; i++) ram[i] = i * 32'h01010101;
        build_exp(DEPTH);
`ifdef UART_WORD_SENDER_CHECKSUM_EN
        chk("model_pin_len8", exp_q.size(), DEPTH * NB + 1);
        chk("model_pin_cksum", exp_q[DEPTH * NB], 8'h70);
`else
        chk("model_pin_len8", exp_q.size(), DEPTH * NB);
        chk("model_pin_last", exp_q[DEPTH * NB - 1], 8'h07);
`endif
        do_run(DEPTH, lat);

        // Start while busy and during the finish cycles is ignored; start one
        // cycle after done begins a new run.
        for (int i = 0; i < DEPTH; i++) ram[i] = $urandom();
        hold_cycles = 6;
        d0 = done_cnt;
        e0 = en_cnt;
        begin_run(2);
        wait_en(e0 + 2);
        start = 1'b1; start_len = (W_A+1)'(1);
        @(posedge CLK); #2;
        start = 1'b0;
        wait_en(e0 + 8);
        start = 1'b1; start_len = (W_A+1)'(1);
        wait_done(d0, lat);
        finish_run(d0);
        d0 = done_cnt;
        build_exp(1);
        exp_len = 1; exp_addr = 0; run_active = 1'b1;
        @(posedge CLK); #2;
        start = 1'b0;
        chk("restart_busy", busy, 1);
        wait_done(d0, lat);
        finish_run(d0);

        // Reset after the third byte of a two-word run.
        hold_cycles = 20;
        d0 = done_cnt;
        e0 = en_cnt;
        begin_run(2);
        wait_en(e0 + 3);
        RST_N = 1'b0;
        #1;
        chk("midrun_reset_outputs", {busy, done, mem_re, send_enable, mem_addr, send_data}, 0);
        exp_q.delete();
        run_active = 1'b0;
        @(posedge CLK); #2;
        RST_N = 1'b1;
        repeat (40) begin @(posedge CLK); #2; end
        chk("no_enable_after_reset", en_cnt - e0, 3);
        chk("no_done_after_reset", done_cnt - d0, 0);
        ram[0] = $urandom();
        do_run(1, lat);

        // UART that never drops ready.
        always_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) ram[i] = $urandom();
        do_run(DEPTH, lat);

        // Randomised runs.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < DEPTH; i++) ram[i] = $urandom();
            always_ready = ($urandom_range(0, 3) == 0);
            hold_cycles  = $urandom_range(1, 20);
            do_run($urandom_range(0, DEPTH), lat);
            repeat ($urandom_range(0, 3)) begin @(posedge CLK); #2; end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_word_sender.md
Name: uart_word_sender

Overview:
- Host-bound counterpart of the UART word loader.
- Reads a run of W_D-bit words from a synchronous single-port RAM and splits each word into bytes, least-significant byte first.
- Issues bytes to the UART transmitter through its one-cycle enable / ready handshake.
- Sits between a word buffer (CoRAM memory or plain BRAM) and the UartTx instance.

Parameters:
- W_D, 32, word width; must be a multiple of 8; bytes per word NB = W_D/8 (localparam).
- W_A, 3, RAM address width; a run holds at most 2**W_A words.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_len  in  W_A+1  number of words to send, 0..2**W_A; sampled with start.
- busy  out  1  high from the cycle after an accepted start until the done cycle (inclusive).
- done  out  1  one-cycle pulse when the run completes.
- mem_addr  out  W_A  RAM read address.
- mem_re  out  1  RAM read enable.
- mem_q  in  W_D  RAM read data; valid the cycle after the RAM samples mem_re.
- send_data  out  8  byte to UART.
- send_enable  out  1  one-cycle byte strobe to UART.
- send_ready  in  1  UART idle; drops the cycle after it samples send_enable.

Behaviour:
- Reset (RST_N=0, immediate): busy, done, mem_re, send_enable = 0; mem_addr, send_data = 0; FSM to IDLE; counters cleared.
- Reset mid-run abandons the run. A byte already strobed into the UART is not retracted. No done pulse.
- All outputs are registered.
- IDLE:
  - start=1 and start_len!=0: latch len, busy<=1, mem_addr<=0, mem_re<=1, go to READ.
  - start=1 and start_len==0: busy<=1, go to FIN; no RAM read, no bytes.
  - start while not in IDLE is ignored.
- READ: mem_re<=0, go to LATCH. The RAM samples the address at this edge.
- LATCH: shift register <= mem_q, byte index <= 0, go to SEND.
- SEND: wait for send_ready=1. Then send_data <= shift[7:0], send_enable <= 1 for exactly one cycle, shift >>= 8, go to GUARD.
- GUARD: one cycle, send_ready ignored, because the UART still reports ready that cycle.
  - If byte index < NB-1: increment it, go to SEND.
  - Else, if more words remain: mem_addr+1, mem_re<=1, go to READ.
  - Else go to DRAIN.
- DRAIN: wait for send_ready=1 (last byte fully shifted out), go to FIN.
- FIN: done<=1 for one cycle, busy<=0 on the following edge together with done<=0, back to IDLE.
  - A start asserted during FIN is ignored. The next start is accepted in IDLE.
- Word count: counter is W_A+1 bits. len = 2**W_A sends every address 0..2**W_A-1; mem_addr never wraps within a run.
- Byte order: byte k of a word is bits [8k+7:8k], k = 0..NB-1, transmitted in increasing k. This round-trips with the loader's packing.
- Throughput: at most one send_enable per UART frame; two send_enable pulses are never closer than 2 cycles.

Optional Feature:
- Macro: UART_WORD_SENDER_CHECKSUM_EN.
- Defined:
  - An 8-bit accumulator clears on accepted start and adds every transmitted byte, mod 256.
  - After the last data byte's GUARD, the FSM goes to CKSUM. CKSUM waits for send_ready, sends the accumulator value as one extra byte with the same GUARD rule, then goes to DRAIN.
  - With len==0 the checksum byte 0x00 is still sent.
- Undefined: no accumulator, no extra byte, and len==0 sends nothing.

Test Plan:
- Words {0x44332211, 0x88776655}, start_len=2; UART model drops ready 1 cycle after enable and holds it low 20 cycles -> bytes 11 22 33 44 55 66 77 88 in order; mem_addr 0 then 1; one done pulse; busy low after it.
- start_len=0 -> no mem_re, no send_enable, done pulses within 3 cycles of start; with CHECKSUM_EN exactly one byte 0x00 is sent.
- start_len=8 (W_A=3), RAM[i] = i*0x01010101 -> 32 bytes; mem_addr reaches 7, no wrap to 0. With CHECKSUM_EN the final byte is 0x70 (sum of 4*i for i=0..7 = 112).
- start pulsed again while busy and again during the FIN cycle -> both ignored; a start one cycle after done is accepted and a new run begins.
- RST_N low for 1 cycle after the 3rd byte of a 2-word run -> all outputs 0 immediately, no further send_enable, no done; a fresh start_len=1 run then completes normally.
- send_ready held at 1 continuously (a UART model that never drops it) -> send_enable pulses separated by at least 2 cycles; no byte is lost or duplicated.
